// File: rtl/nor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nor_pkg
// Purpose  : Shared types and constants for the QPI (4-4-4) NOR flash reader.
// Revision : 1.0
// ============================================================================
package nor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4,
        ST_RECOV = 3'd5
    } nor_state_t;

    localparam logic [7:0] C_CMD_DEFAULT = 8'hEB;
    localparam int         C_CMD_SCK     = 2;
    localparam int         C_ADDR_SCK    = 6;

endpackage
`default_nettype wire

// File: rtl/nor_qpi_reader.sv
`default_nettype none
// ============================================================================
// Module   : nor_qpi_reader
// Purpose  : Reads byte bursts from a QPI NOR flash (4-4-4 mode, SCK = clk/2).
// Revision : 1.0
// ============================================================================
module nor_qpi_reader
    import nor_pkg::*;
#(
    parameter logic [7:0] CMD      = C_CMD_DEFAULT,
    parameter int         DUMMY    = 6,
    parameter int         CSB_IDLE = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [23:0] req_addr,
    input  logic [7:0]  req_len,
    input  logic        abort,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [7:0]  rsp_data,
    output logic        busy,
    output logic        nor_sck,
    output logic        nor_csb,
    output logic [3:0]  nor_sio_o,
    output logic [3:0]  nor_sio_oe,
    input  logic [3:0]  nor_sio_i
);

    localparam logic [7:0] c_cmd_last   = 8'(C_CMD_SCK - 1);
    localparam logic [7:0] c_addr_last  = 8'(C_ADDR_SCK - 1);
    localparam logic [7:0] c_dummy_last = 8'(DUMMY - 1);
    localparam logic [7:0] c_recov_last = 8'(2 * CSB_IDLE - 1);

    nor_state_t  r_state;
    logic        r_ph;      // 1: the next clk edge begins a new L phase
    logic [7:0]  r_cnt;
    logic [9:0]  r_left;    // data nibbles still to be clocked in
    logic [31:0] r_osr;
    logic        r_samp;
    logic        r_nib;
    logic        r_abt;
    logic        r_pend;
    logic [3:0]  r_sh;
    logic [7:0]  r_byte;

    logic w_active;
    logic w_xfer;
    logic w_stall;
    logic w_abort;

    assign w_active = (r_state != ST_IDLE) && (r_state != ST_RECOV);
    assign w_xfer   = r_pend && (!rsp_vld || rsp_rdy);
    // A complete byte still waiting for the output register freezes SCK low.
    assign w_stall  = r_samp && r_pend && !w_xfer;
    assign w_abort  = w_active && (r_abt || abort);

    assign req_rdy = (r_state == ST_IDLE);
    assign busy    = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ph       <= 1'b0;
            r_cnt      <= 8'd0;
            r_left     <= 10'd0;
            r_osr      <= 32'd0;
            r_samp     <= 1'b0;
            r_nib      <= 1'b0;
            r_abt      <= 1'b0;
            r_pend     <= 1'b0;
            r_sh       <= 4'd0;
            r_byte     <= 8'd0;
            rsp_vld    <= 1'b0;
            rsp_data   <= 8'd0;
            nor_sck    <= 1'b0;
            nor_csb    <= 1'b1;
            nor_sio_o  <= 4'd0;
            nor_sio_oe <= 4'd0;
        end else begin
            if (w_xfer) begin
                rsp_vld  <= 1'b1;
                rsp_data <= r_byte;
                r_pend   <= 1'b0;
            end else if (rsp_rdy) begin
                rsp_vld  <= 1'b0;
            end

            if (w_active && abort) begin
                r_abt <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (req_vld) begin
                        r_state <= ST_CMD;
                        r_cnt   <= 8'd0;
                        r_ph    <= 1'b1;
                        r_osr   <= {CMD, req_addr};
                        r_left  <= {1'b0, req_len, 1'b0} + 10'd2;
                        r_abt   <= 1'b0;
                        r_nib   <= 1'b0;
                        r_samp  <= 1'b0;
                    end
                end
                ST_RECOV: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt == c_recov_last) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= 8'd0;
                    end
                end
                default: begin
                    if ((r_ph || w_stall) && w_abort) begin
                        r_state    <= ST_RECOV;
                        r_cnt      <= 8'd0;
                        r_ph       <= 1'b0;
                        r_samp     <= 1'b0;
                        r_abt      <= 1'b0;
                        nor_csb    <= 1'b1;
                        nor_sck    <= 1'b0;
                        nor_sio_oe <= 4'd0;
                        nor_sio_o  <= 4'd0;
                    end else if (r_ph) begin
                        r_ph    <= 1'b0;
                        nor_sck <= 1'b0;
                        r_cnt   <= r_cnt + 8'd1;
                        case (r_state)
                            ST_CMD, ST_ADDR: begin
                                nor_csb    <= 1'b0;
                                nor_sio_oe <= 4'hF;
                                nor_sio_o  <= r_osr[31:28];
                                r_osr      <= {r_osr[27:0], 4'd0};
                                if (r_state == ST_CMD && r_cnt == c_cmd_last) begin
                                    r_state <= ST_ADDR;
                                    r_cnt   <= 8'd0;
                                end else if (r_state == ST_ADDR && r_cnt == c_addr_last) begin
                                    r_state <= ST_DUMMY;
                                    r_cnt   <= 8'd0;
                                end
                            end
                            ST_DUMMY: begin
                                nor_sio_oe <= 4'd0;
                                nor_sio_o  <= 4'd0;
                                if (r_cnt == c_dummy_last) begin
                                    r_state <= ST_DATA;
                                    r_cnt   <= 8'd0;
                                end
                            end
                            ST_DATA: begin
                                if (r_left == 10'd0) begin
                                    r_state <= ST_RECOV;
                                    r_cnt   <= 8'd0;
                                    r_samp  <= 1'b0;
                                    nor_csb <= 1'b1;
                                end else begin
                                    r_left <= r_left - 10'd1;
                                    r_samp <= 1'b1;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else if (!w_stall) begin
                        nor_sck <= 1'b1;
                        r_ph    <= 1'b1;
                        if (r_samp) begin
                            r_nib <= !r_nib;
                            if (r_nib) begin
                                r_byte <= {r_sh, nor_sio_i};
                                r_pend <= 1'b1;
                            end else begin
                                r_sh <= nor_sio_i;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_nor_qpi_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_nor_qpi_reader
// Purpose  : Directed and randomized checks of nor_qpi_reader against a flash model.
// Revision : 1.0
// ============================================================================
module tb_nor_qpi_reader;

    localparam int c_dummy    = 6;
    localparam int c_csb_idle = 2;
    localparam int c_limit    = 4000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [23:0] req_addr = 24'd0;
    logic [7:0]  req_len = 8'd0;
    logic        abort = 1'b0;
    logic        rsp_vld;
    logic        rsp_rdy = 1'b1;
    logic [7:0]  rsp_data;
    logic        busy;
    logic        nor_sck;
    logic        nor_csb;
    logic [3:0]  nor_sio_o;
    logic [3:0]  nor_sio_oe;
    logic [3:0]  nor_sio_i = 4'd0;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t_acc = 0;
    logic [7:0]  seed = 8'd0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          got_t[$];
    int          fl_edges = 0;
    logic [31:0] fl_hdr = 32'd0;
    int          oe_bad = 0;

    nor_qpi_reader #(
        .CMD      (8'hEB),
        .DUMMY    (c_dummy),
        .CSB_IDLE (c_csb_idle)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_vld    (req_vld),
        .req_rdy    (req_rdy),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .abort      (abort),
        .rsp_vld    (rsp_vld),
        .rsp_rdy    (rsp_rdy),
        .rsp_data   (rsp_data),
        .busy       (busy),
        .nor_sck    (nor_sck),
        .nor_csb    (nor_csb),
        .nor_sio_o  (nor_sio_o),
        .nor_sio_oe (nor_sio_oe),
        .nor_sio_i  (nor_sio_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Flash array contents: a fixed marker at 0x10, a seeded pattern elsewhere.
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a == 24'h000010) return 8'hA5;
        return a[7:0] ^ a[15:8] ^ {a[19:16], a[23:20]} ^ seed;
    endfunction

    always @(negedge nor_csb) begin
        fl_edges = 0;
        fl_hdr   = 32'd0;
    end

    // Flash: opcode+address captured on rising SCK; data nibble for the next
    // rising edge is presented right after the current one.
    always @(posedge nor_sck) begin
        int         d;
        logic [7:0] b;
        if (!nor_csb) begin
            fl_edges++;
            if (fl_edges <= 8) begin
                fl_hdr = {fl_hdr[27:0], nor_sio_o};
                if (nor_sio_oe !== 4'hF) oe_bad++;
            end else if (nor_sio_oe !== 4'h0) begin
                oe_bad++;
            end
            d = fl_edges - (8 + c_dummy);
            if (d >= 0) begin
                b = mem_byte(fl_hdr[23:0] + 24'(d / 2));
                nor_sio_i = (d % 2 == 0) ? b[7:4] : b[3:0];
            end
        end
    end

    always @(negedge clk) begin
        if (rsp_vld && rsp_rdy) begin
            got_q.push_back(rsp_data);
            got_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [23:0] a, input logic [7:0] l, input logic ab);
        req_addr = a;
        req_len  = l;
        req_vld  = 1'b1;
        abort    = ab;
        t_acc    = cyc + 1;
        exp_q    = {};
        got_q    = {};
        got_t    = {};
        for (int i = 0; i <= int'(l); i++) exp_q.push_back(mem_byte(a + 24'(i)));
        @(negedge clk);
        req_vld = 1'b0;
        abort   = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input logic rnd_rdy);
        int n = 0;
        while ((busy || rsp_vld) && n < c_limit) begin
            if (rnd_rdy) rsp_rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        rsp_rdy = 1'b1;
        check({tag, " timeout"}, 32'(n < c_limit), 32'd1);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_bytes(input string tag, input int n_exp);
        int bad = 0;
        check({tag, " count"}, 32'(got_q.size()), 32'(n_exp));
        for (int i = 0; i < n_exp && i < got_q.size(); i++)
            if (got_q[i] !== exp_q[i]) bad++;
        check({tag, " data"}, 32'(bad), 32'd0);
    endtask

    initial begin
        int         sck_hi;
        int         gap_bad;
        logic [23:0] a;
        logic [7:0]  l;

        seed = 8'($urandom);
        repeat (3) @(negedge clk);
        check("rst csb", 32'(nor_csb), 32'd1);
        check("rst sck", 32'(nor_sck), 32'd0);
        check("rst oe", 32'(nor_sio_oe), 32'd0);
        check("rst sio_o", 32'(nor_sio_o), 32'd0);
        check("rst rsp_vld", 32'(rsp_vld), 32'd0);
        check("rst rsp_data", 32'(rsp_data), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst req_rdy", 32'(req_rdy), 32'd1);

        // Single byte: latency, data and recovery timing
        start_req(24'h000010, 8'd0, 1'b0);
        wait_until(t_acc + 33);
        check("single csb high", 32'(nor_csb), 32'd1);
        wait_until(t_acc + 36);
        check("single busy in recov", 32'(busy), 32'd1);
        wait_until(t_acc + 37);
        check("single busy clear", 32'(busy), 32'd0);
        wait_idle("single", 1'b0);
        check_bytes("single", 1);
        check("single latency", 32'(got_t.size() > 0 ? got_t[0] - t_acc : -1), 32'd33);
        check("single header", fl_hdr, {8'hEB, 24'h000010});

        // 256-byte burst
        start_req(24'h000000, 8'd255, 1'b0);
        wait_idle("burst", 1'b0);
        check_bytes("burst", 256);
        gap_bad = 0;
        for (int i = 1; i < got_t.size(); i++)
            if (got_t[i] - got_t[i-1] != 4) gap_bad++;
        check("burst spacing", 32'(gap_bad), 32'd0);
        check("burst header", fl_hdr, 32'hEB000000);
        check("burst oe", 32'(oe_bad), 32'd0);

        // Backpressure: hold rsp_rdy low for 20 clk after the first byte
        start_req(24'($urandom), 8'd3, 1'b0);
        wait_until(t_acc + 33);
        @(negedge clk);
        rsp_rdy = 1'b0;
        sck_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cyc >= t_acc + 42 && nor_sck) sck_hi++;
        end
        check("bp sck frozen", 32'(sck_hi), 32'd0);
        check("bp vld held", 32'(rsp_vld), 32'd1);
        rsp_rdy = 1'b1;
        wait_idle("bp", 1'b0);
        check_bytes("bp", 4);

        // Abort during the second data byte
        start_req(24'($urandom), 8'd3, 1'b0);
        wait_until(t_acc + 33);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check("abort csb high", 32'(nor_csb), 32'd1);
        check("abort oe", 32'(nor_sio_oe), 32'd0);
        wait_until(t_acc + 39);
        check("abort busy clear", 32'(busy), 32'd0);
        wait_idle("abort", 1'b0);
        check_bytes("abort", 1);

        // Address wrap
        start_req(24'hFFFFFF, 8'd1, 1'b0);
        wait_idle("wrap", 1'b0);
        check_bytes("wrap", 2);

        // Reset during the address phase
        start_req(24'($urandom), 8'd2, 1'b0);
        wait_until(t_acc + 6);
        rst = 1'b1;
        #1;
        check("midrst csb", 32'(nor_csb), 32'd1);
        check("midrst sck", 32'(nor_sck), 32'd0);
        check("midrst oe", 32'(nor_sio_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("midrst no rsp", 32'(got_q.size()), 32'd0);
        a = 24'($urandom);
        start_req(a, 8'd4, 1'b0);
        wait_idle("after rst", 1'b0);
        check_bytes("after rst", 5);
        check("after rst header", fl_hdr, {8'hEB, a});

        // Request and abort together in IDLE: abort ignored
        start_req(24'($urandom), 8'd2, 1'b1);
        wait_idle("req+abort", 1'b0);
        check_bytes("req+abort", 3);

        // Randomized transactions with random consumer readiness
        for (int k = 0; k < 6; k++) begin
            a = 24'($urandom);
            l = 8'($urandom_range(0, 15));
            start_req(a, l, 1'b0);
            wait_idle("rand", 1'b1);
            check_bytes("rand", int'(l) + 1);
            check("rand header", fl_hdr, {8'hEB, a});
        end
        check("final oe", 32'(oe_bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
